// File: rtl/avg_count_ctrl.sv
// Running-average event counter sequencer: start/pause/resume/clear control.
// Optional key debounce enabled by defining AVG_CTRL_DEBOUNCE_EN.
module avg_count_ctrl #(
    parameter int PEND_W     = 8,
    parameter int CLR_CYCLES = 4,
    parameter int DB_CYCLES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_start_n,
    input  logic              key_pause_n,
    input  logic              key_clear_n,
    input  logic              sample_vld,
    output logic              cnt_en,
    output logic              cnt_clr_n,
    output logic [2:0]        state,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              pend_ovf
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DRAIN = 3'd3,
        CLEAR = 3'd4
    } state_t;

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    // Key bit order: {clear, pause, start}
    logic [2:0] keys;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] lvl;
    logic [2:0] lvl_prev;
    logic [2:0] cmd;

    assign keys = {key_clear_n, key_pause_n, key_start_n};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '1;
            sync2    <= '1;
            lvl_prev <= '1;
            cmd      <= '0;
        end else begin
            sync1    <= keys;
            sync2    <= sync1;
            lvl_prev <= lvl;
            cmd      <= lvl_prev & ~lvl;
        end
    end

`ifdef AVG_CTRL_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] db_cnt [3];

    // Level follows the synchronizer only after DB_CYCLES stable samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl <= '1;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    lvl[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign lvl = sync2;
`endif

    logic             do_start;
    logic             do_pause;
    logic             do_clear;
    logic             pend_full;
    logic             active;
    logic [CLR_W-1:0] clr_cnt;
    state_t           st;

    assign do_start  = cmd[0];
    assign do_pause  = cmd[1];
    assign do_clear  = cmd[2];
    assign pend_full = (pend_cnt == PEND_MAX);
    assign active    = st inside {IDLE, RUN, PAUSE, DRAIN};
    assign state     = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            cnt_en    <= 1'b0;
            cnt_clr_n <= 1'b1;
            pend_cnt  <= '0;
            pend_ovf  <= 1'b0;
            clr_cnt   <= '0;
        end else begin
            cnt_en <= 1'b0;
            if (do_clear && active) begin
                st        <= CLEAR;
                cnt_clr_n <= 1'b0;
                clr_cnt   <= '0;
                pend_cnt  <= '0;
                pend_ovf  <= 1'b0;
            end else begin
                unique case (st)
                    IDLE: begin
                        if (do_start) st <= RUN;
                    end
                    RUN: begin
                        cnt_en <= sample_vld;
                        if (do_pause) st <= PAUSE;
                    end
                    PAUSE: begin
                        if (sample_vld) begin
                            if (pend_full) pend_ovf <= 1'b1;
                            else pend_cnt <= pend_cnt + 1'b1;
                        end
                        if (do_start)
                            st <= (pend_cnt != '0 || sample_vld) ? DRAIN : RUN;
                    end
                    DRAIN: begin
                        if (do_pause) begin
                            st <= PAUSE;
                            if (sample_vld) begin
                                if (pend_full) pend_ovf <= 1'b1;
                                else pend_cnt <= pend_cnt + 1'b1;
                            end
                        end else begin
                            cnt_en <= 1'b1;
                            // A new sample replaces the one drained this cycle
                            if (!sample_vld) begin
                                if (pend_cnt <= PEND_ONE) begin
                                    pend_cnt <= '0;
                                    st       <= RUN;
                                end else begin
                                    pend_cnt <= pend_cnt - 1'b1;
                                end
                            end
                        end
                    end
                    CLEAR: begin
                        pend_cnt <= '0;
                        pend_ovf <= 1'b0;
                        if (clr_cnt == CLR_LAST) begin
                            st        <= IDLE;
                            cnt_clr_n <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                    default: begin
                        st        <= IDLE;
                        cnt_clr_n <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_avg_count_ctrl.sv
// Randomized bench for avg_count_ctrl against a cycle model of the control rules.
// Debounce checks are built in when AVG_CTRL_DEBOUNCE_EN is defined.
module tb_avg_count_ctrl;

    localparam int PW   = 3;
    localparam int PMAX = (1 << PW) - 1;
    localparam int CLR  = 4;
    localparam int DB   = 16;
`ifdef AVG_CTRL_DEBOUNCE_EN
    localparam int PRESS = DB + 4;
`else
    localparam int PRESS = 3;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DRAIN = 3;
    localparam int M_CLEAR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          key_start_n = 1'b1;
    logic          key_pause_n = 1'b1;
    logic          key_clear_n = 1'b1;
    logic          sample_vld = 1'b0;
    logic          cnt_en;
    logic          cnt_clr_n;
    logic [2:0]    state;
    logic [PW-1:0] pend_cnt;
    logic          pend_ovf;

    int errors = 0;
    int checks = 0;
    int en_seen = 0;
    int hold = 0;

    avg_count_ctrl #(
        .PEND_W(PW),
        .CLR_CYCLES(CLR),
        .DB_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_start_n(key_start_n),
        .key_pause_n(key_pause_n),
        .key_clear_n(key_clear_n),
        .sample_vld(sample_vld),
        .cnt_en(cnt_en),
        .cnt_clr_n(cnt_clr_n),
        .state(state),
        .pend_cnt(pend_cnt),
        .pend_ovf(pend_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: keys are sampled on each edge, commands are the
    // falling edges of the (optionally debounced) level, 3 edges later.
    logic [2:0] kq [0:DB+1];
    logic [2:0] lq [0:2];
    logic [2:0] m_cmd;
    logic [2:0] m_nl;
    bit         m_flip;
    int         m_mode = 0;
    int         m_pend = 0;
    int         m_clr = 0;
    bit         m_ovf = 1'b0;
    bit         m_en = 1'b0;

    function automatic void m_buffer();
        if (m_pend == PMAX) m_ovf = 1'b1;
        else m_pend++;
    endfunction

    function automatic void m_enter_clear();
        m_mode = M_CLEAR;
        m_clr  = CLR;
        m_pend = 0;
        m_ovf  = 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j <= DB + 1; j++) kq[j] = 3'b111;
            for (int j = 0; j < 3; j++) lq[j] = 3'b111;
            m_mode = M_IDLE;
            m_pend = 0;
            m_clr  = 0;
            m_ovf  = 1'b0;
            m_en   = 1'b0;
        end else begin
            m_cmd = lq[2] & ~lq[1];
`ifdef AVG_CTRL_DEBOUNCE_EN
            m_nl = lq[0];
            for (int b = 0; b < 3; b++) begin
                m_flip = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (kq[j][b] == lq[0][b]) m_flip = 1'b0;
                if (m_flip) m_nl[b] = ~lq[0][b];
            end
`else
            m_nl = kq[0];
`endif
            lq[2] = lq[1];
            lq[1] = lq[0];
            lq[0] = m_nl;
            for (int j = DB + 1; j > 0; j--) kq[j] = kq[j-1];
            kq[0] = {key_clear_n, key_pause_n, key_start_n};
            m_en = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (m_cmd[2]) m_enter_clear();
                    else if (m_cmd[0]) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (m_cmd[2]) m_enter_clear();
                    else begin
                        m_en = sample_vld;
                        if (m_cmd[1]) m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: begin
                    if (m_cmd[2]) m_enter_clear();
                    else begin
                        if (sample_vld) m_buffer();
                        if (m_cmd[0]) m_mode = (m_pend != 0) ? M_DRAIN : M_RUN;
                    end
                end
                M_DRAIN: begin
                    if (m_cmd[2]) m_enter_clear();
                    else if (m_cmd[1]) begin
                        if (sample_vld) m_buffer();
                        m_mode = M_PAUSE;
                    end else begin
                        m_en   = 1'b1;
                        m_pend = m_pend - 1 + int'(sample_vld);
                        if (m_pend == 0) m_mode = M_RUN;
                    end
                end
                default: begin
                    m_clr--;
                    if (m_clr == 0) m_mode = M_IDLE;
                end
            endcase
        end
        #1;
        chk("state", int'(state), m_mode);
        chk("cnt_en", int'(cnt_en), int'(m_en));
        chk("cnt_clr_n", int'(cnt_clr_n), int'(m_mode != M_CLEAR));
        chk("pend_cnt", int'(pend_cnt), m_pend);
        chk("pend_ovf", int'(pend_ovf), int'(m_ovf));
        if (cnt_en) en_seen++;
    end

    // Key release after the hold time
    always @(negedge clk) begin
        if (hold > 0) begin
            hold--;
            if (hold == 0) begin
                key_start_n = 1'b1;
                key_pause_n = 1'b1;
                key_clear_n = 1'b1;
            end
        end
    end

    // mask bits: 0 start, 1 pause, 2 clear
    task automatic press(input logic [2:0] m);
        if (m[0]) key_start_n = 1'b0;
        if (m[1]) key_pause_n = 1'b0;
        if (m[2]) key_clear_n = 1'b0;
        hold = PRESS;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int exp, input string nm);
        int n = 0;
        while (int'(state) != exp && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(state), exp);
    endtask

    task automatic samples(input int n);
        for (int i = 0; i < n; i++) begin
            sample_vld = 1'b1;
            @(negedge clk);
            sample_vld = 1'b0;
            @(negedge clk);
        end
    endtask

    int base;
    int nlow;
    int r;

    initial begin
        tick(3);
        chk("rst_state", int'(state), 0);
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_clr_n", int'(cnt_clr_n), 1);
        chk("rst_pend", int'(pend_cnt), 0);
        chk("rst_ovf", int'(pend_ovf), 0);
        rst = 1'b1;
        tick(2);

        press(3'b001);
        wait_state(M_RUN, "t1_run");
        base = en_seen;
        samples(5);
        tick(2);
        chk("t1_pulses", en_seen - base, 5);
        chk("t1_clr_n", int'(cnt_clr_n), 1);

        press(3'b010);
        wait_state(M_PAUSE, "t2_pause");
        samples(3);
        chk("t2_pend", int'(pend_cnt), 3);
        press(3'b001);
        wait_state(M_DRAIN, "t2_drain");
        base = en_seen;
        wait_state(M_RUN, "t2_run");
        chk("t2_pulses", en_seen - base, 3);
        chk("t2_pend0", int'(pend_cnt), 0);

        press(3'b010);
        wait_state(M_PAUSE, "t4_pause");
        samples(4);
        chk("t4_pend", int'(pend_cnt), 4);
        press(3'b001);
        wait_state(M_DRAIN, "t4_drain");
        base = en_seen;
        sample_vld = 1'b1;
        tick(2);
        sample_vld = 1'b0;
        chk("t4_hold", int'(pend_cnt), 4);
        wait_state(M_RUN, "t4_run");
        chk("t4_pulses", en_seen - base, 6);

        press(3'b010);
        wait_state(M_PAUSE, "t3_pause");
        samples(9);
        chk("t3_pend", int'(pend_cnt), PMAX);
        chk("t3_ovf", int'(pend_ovf), 1);
        press(3'b001);
        wait_state(M_DRAIN, "t3_drain");
        base = en_seen;
        wait_state(M_RUN, "t3_run");
        chk("t3_pulses", en_seen - base, PMAX);

        press(3'b110);
        wait_state(M_CLEAR, "t5_clear");
        nlow = 0;
        while (cnt_clr_n == 1'b0 && nlow < 20) begin
            nlow++;
            @(negedge clk);
        end
        chk("t5_clr_len", nlow, CLR);
        chk("t5_ovf", int'(pend_ovf), 0);
        chk("t5_idle", int'(state), M_IDLE);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                hold = 0;
                key_start_n = 1'b1;
                key_pause_n = 1'b1;
                key_clear_n = 1'b1;
                sample_vld = 1'b0;
                #2 rst = 1'b0;
                #1;
                chk("arst_state", int'(state), 0);
                chk("arst_pend", int'(pend_cnt), 0);
                chk("arst_clr_n", int'(cnt_clr_n), 1);
                @(negedge clk);
                rst = 1'b1;
            end else begin
                sample_vld = ($urandom_range(0, 99) < 35);
                if (hold == 0 && $urandom_range(0, 99) < 4) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: press(3'b001);
                        4, 5, 6:    press(3'b010);
                        7:          press(3'b100);
                        8:          press(3'b110);
                        default:    press(3'b011);
                    endcase
                end
            end
        end
        sample_vld = 1'b0;

`ifdef AVG_CTRL_DEBOUNCE_EN
        hold = 0;
        key_start_n = 1'b1;
        key_pause_n = 1'b1;
        key_clear_n = 1'b1;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        key_start_n = 1'b0;
        tick(10);
        key_start_n = 1'b1;
        tick(40);
        chk("db_glitch", int'(state), M_IDLE);
        key_start_n = 1'b0;
        tick(20);
        key_start_n = 1'b1;
        tick(10);
        chk("db_press", int'(state), M_RUN);
`endif

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
